// File: rtl/kbd_pkg.sv
// Shared types and default parameters for the keyboard event arbiter and its buffer.
package kbd_pkg;

    localparam int GAP_CYCLES_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic       press;
        logic       ext;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } kbd_state_t;

    function automatic logic [10:0] packKeyOut(input logic toggle, input kbd_event_t ev);
        return {toggle, ev};
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Circular buffer of live keyboard events; a push into a full buffer is
// accepted only when a pop frees a slot on the same edge.
module kbd_event_fifo import kbd_pkg::*; #(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [9:0] i_data,
    output logic [9:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    kbd_event_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_count;

    logic            w_doPush;
    logic            w_doPop;

    assign o_full   = (r_count == FULL_COUNT);
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_head   = r_mem[r_rdPtr];

    always_ff @(posedge clk_sys) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= kbd_event_t'(i_data);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_arbiter.sv
// Merges live PS/2 key events with injected events into one toggle-signalled
// stream, enforcing a minimum idle gap between output events.
module kbd_event_arbiter import kbd_pkg::*; #(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key_in,
    input  logic        inj_valid,
    output logic        inj_ready,
    input  logic [8:0]  inj_code,
    input  logic        inj_press,
    output logic [10:0] ps2_key_out,
    output logic        busy,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    kbd_state_t  r_state;
    logic [7:0]  r_gapCnt;
    logic [10:0] r_keyOut;
    logic        r_prevToggle;
    logic        r_primed;
    logic        r_overflow;

    logic        w_liveEvent;
    logic        w_pop;
    logic        w_injFire;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    logic [9:0]  w_head;
    logic [9:0]  w_emitData;

    kbd_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_push  (w_liveEvent),
        .i_pop   (w_pop),
        .i_data  (ps2_key_in[9:0]),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The first edge after reset only primes r_prevToggle, so a stale toggle level is not an event.
    assign w_liveEvent = r_primed && (ps2_key_in[10] != r_prevToggle);
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign inj_ready   = (r_state == IDLE) && w_empty;
    assign w_injFire   = inj_valid && inj_ready;
    assign w_drop      = w_liveEvent && w_full && !w_pop;
    assign w_emitData  = w_pop ? w_head : {inj_press, inj_code};

    assign ps2_key_out = r_keyOut;
    assign overflow    = r_overflow;
    assign busy        = (r_state != IDLE) || !w_empty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_prevToggle <= 1'b0;
            r_primed     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_prevToggle <= ps2_key_in[10];
            r_primed     <= 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_gapCnt <= '0;
            r_keyOut <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop || w_injFire) begin
                        r_keyOut <= packKeyOut(~r_keyOut[10], kbd_event_t'(w_emitData));
                        r_gapCnt <= GAP_LOAD;
                        r_state  <= GAP;
                    end
                end
                GAP: begin
                    if (r_gapCnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_event_arbiter.sv
// Scoreboard bench: a queue/timestamp reference model predicts every output
// event and a monitor compares the DUT stream, flags and handshake against it.
module tb_kbd_event_arbiter;

    localparam int GAP_N = 16;
    localparam int DEPTH = 4;

    logic        clk_sys      = 1'b0;
    logic        reset_n      = 1'b0;
    logic [10:0] ps2_key_in   = '0;
    logic        inj_valid    = 1'b0;
    logic [8:0]  inj_code     = '0;
    logic        inj_press    = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        inj_ready;
    logic [10:0] ps2_key_out;
    logic        busy;
    logic        overflow;

    kbd_event_arbiter #(
        .GAP_CYCLES(GAP_N),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_key_in   (ps2_key_in),
        .inj_valid    (inj_valid),
        .inj_ready    (inj_ready),
        .inj_code     (inj_code),
        .inj_press    (inj_press),
        .ps2_key_out  (ps2_key_out),
        .busy         (busy),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [10:0] value;
        int          cycle;
    } exp_t;

    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    int          lastEmit   = -100000;
    int          injAccepts = 0;
    logic [9:0]  mq[$];
    exp_t        expQ[$];
    bit          primed     = 0;
    logic        prevTog    = 1'b0;
    logic        mToggle    = 1'b0;
    logic        mOverflow  = 1'b0;
    logic [10:0] monLast    = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic emitModel(input logic [9:0] ev);
        exp_t e;
        mToggle  = ~mToggle;
        e.value  = {mToggle, ev};
        e.cycle  = cyc;
        expQ.push_back(e);
        lastEmit = cyc;
    endtask

    // Reference model: an output may leave GAP_N+1 clocks after the previous
    // one; live events wait in a bounded queue and always beat the injector.
    always @(posedge clk_sys or negedge reset_n) begin
        logic [9:0] ev;
        bit         idleNow;
        bit         dropped;
        if (!reset_n) begin
            mq.delete();
            expQ.delete();
            lastEmit  = -100000;
            primed    = 0;
            prevTog   = 1'b0;
            mToggle   = 1'b0;
            mOverflow = 1'b0;
        end else begin
            cyc++;
            idleNow = (cyc - lastEmit) >= GAP_N + 1;
            dropped = 0;
            if (idleNow && mq.size() > 0) begin
                ev = mq.pop_front();
                emitModel(ev);
            end else if (idleNow && inj_valid) begin
                emitModel({inj_press, inj_code});
                injAccepts++;
            end
            if (primed && (ps2_key_in[10] != prevTog)) begin
                if (mq.size() < DEPTH) mq.push_back(ps2_key_in[9:0]);
                else dropped = 1;
            end
            if (dropped) mOverflow = 1'b1;
            else if (clr_overflow) mOverflow = 1'b0;
            primed  = 1;
            prevTog = ps2_key_in[10];
        end
    end

    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset_n) begin
            checkOutput("resetOut", 32'(ps2_key_out), 32'd0);
            monLast = '0;
        end else begin
            if (ps2_key_out[10] !== monLast[10]) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEvent: got 0x%0h expected no event (cycle %0d)", ps2_key_out, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("eventValue", 32'(ps2_key_out), 32'(e.value));
                    checkOutput("eventCycle", cyc, e.cycle);
                end
                monLast = ps2_key_out;
            end else begin
                checkOutput("holdValue", 32'(ps2_key_out), 32'(monLast));
            end
            checkOutput("injReady", 32'(inj_ready),
                        32'(((cyc + 1 - lastEmit) >= GAP_N + 1) && (mq.size() == 0)));
            checkOutput("busy", 32'(busy), 32'((cyc < lastEmit + GAP_N) || (mq.size() != 0)));
            checkOutput("overflow", 32'(overflow), 32'(mOverflow));
        end
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] data);
        ps2_key_in = {~ps2_key_in[10], data};
    endtask

    task automatic waitInject(input int startCount);
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (injAccepts != startCount) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL injectTimeout: got no acceptance expected acceptance within 300 cycles");
        end
        inj_valid = 1'b0;
    endtask

    initial begin
        int injMark;

        // Reset released with the toggle line high: priming must not create an event.
        ps2_key_in = 11'h400;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        checkOutput("idleOut", 32'(ps2_key_out), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);

        applyStimulus(10'h21C);
        tick();
        tick();
        checkOutput("firstEvent", 32'(ps2_key_out), 32'h61C);
        checkOutput("firstBusy", 32'(busy), 32'd1);
        repeat (30) tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(10'($urandom));
            tick();
        end
        checkOutput("burstNoDrop", 32'(overflow), 32'd0);
        repeat (100) tick();

        applyStimulus(10'($urandom));
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(10'($urandom));
            tick();
        end
        checkOutput("dropSetsOverflow", 32'(overflow), 32'd1);
        repeat (120) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checkOutput("clearOverflow", 32'(overflow), 32'd0);
        repeat (5) tick();

        applyStimulus(10'h2F0);
        tick();
        inj_code  = 9'h05A;
        inj_press = 1'b1;
        inj_valid = 1'b1;
        #1;
        checkOutput("injBlocked", 32'(inj_ready), 32'd0);
        waitInject(injAccepts);
        repeat (40) tick();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(10'($urandom));
            tick();
        end
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("resetImmediate", 32'(ps2_key_out), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (80) tick();

        injMark = injAccepts;
        for (int i = 0; i < 400; i++) begin
            if (inj_valid && injAccepts != injMark) inj_valid = 1'b0;
            if (!inj_valid && $urandom_range(0, 9) == 0) begin
                inj_code  = 9'($urandom);
                inj_press = 1'($urandom_range(0, 1));
                inj_valid = 1'b1;
                injMark   = injAccepts;
            end
            if ($urandom_range(0, 5) == 0) applyStimulus(10'($urandom));
            clr_overflow = ($urandom_range(0, 19) == 0);
            tick();
        end
        inj_valid    = 1'b0;
        clr_overflow = 1'b0;
        repeat (300) tick();

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
